// File: rtl/shift_mix_columns_if.sv
// Handshake bundle between SubBytes, the ShiftRows/MixColumns stage and AddRoundKey.
// The slave modport is the stage's own view; master is the surrounding datapath.
interface shift_mix_columns_if;
   logic [0:127] i_data;
   logic         i_valid;
   logic         o_ready;
   logic         i_last_round;
   logic [0:127] o_data;
   logic         o_valid;
   logic         i_ready;
   logic         o_busy;

   modport slave (
      input  i_data, i_valid, i_last_round, i_ready,
      output o_ready, o_data, o_valid, o_busy
   );

   modport master (
      output i_data, i_valid, i_last_round, i_ready,
      input  o_ready, o_data, o_valid, o_busy
   );
endinterface

// File: rtl/shift_mix_columns.sv
// AES round stage: ShiftRows on capture, then column-serial MixColumns in place.
// The final round skips MixColumns but keeps the same latency.
module shift_mix_columns #(
   parameter int COLS_PER_CYCLE = 1
) (
   input logic               i_clock,
   input logic               i_reset_n,
   shift_mix_columns_if.slave io_bus
);

   localparam int         NCYC     = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_CYC = 2'(NCYC - 1);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_badParam
      $error("shift_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       r_fsm;
   state_t       w_next;
   logic         w_ready;
   logic         w_accept;
   logic [0:127] r_data;
   logic [0:127] w_mixed;
   logic [1:0]   r_cyc;
   logic         r_last;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mixColumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      // 3a = 2a ^ a
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [0:127] shiftRows(input logic [0:127] s);
      logic [0:127] res;
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      return res;
   endfunction

   always_comb begin
      w_next  = r_fsm;
      w_ready = 1'b0;
      case (r_fsm)
         IDLE: begin
            w_ready = 1'b1;
            if (io_bus.i_valid) w_next = BUSY;
         end
         BUSY: begin
            if (r_cyc == LAST_CYC) w_next = DONE;
         end
         DONE: begin
            w_ready = io_bus.i_ready;
            if (io_bus.i_ready) w_next = io_bus.i_valid ? BUSY : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept = io_bus.i_valid & w_ready;

   // Columns owned by the current cycle are c / COLS_PER_CYCLE == r_cyc.
   always_comb begin
      w_mixed = r_data;
      for (int c = 0; c < 4; c++) begin
         if ((c / COLS_PER_CYCLE) == int'(r_cyc) && !r_last)
            w_mixed[32*c +: 32] = mixColumn(r_data[32*c +: 32]);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_fsm <= IDLE;
      else            r_fsm <= w_next;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_data <= '0;
         r_cyc  <= 2'd0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_data <= shiftRows(io_bus.i_data);
         r_cyc  <= 2'd0;
         r_last <= io_bus.i_last_round;
      end else if (r_fsm == BUSY) begin
         r_data <= w_mixed;
         r_cyc  <= r_cyc + 2'd1;
      end
   end

   // Output is gated to zero outside DONE so a partial state is never visible.
   assign io_bus.o_data  = (r_fsm == DONE) ? r_data : '0;
   assign io_bus.o_valid = (r_fsm == DONE);
   assign io_bus.o_ready = w_ready;
   assign io_bus.o_busy  = (r_fsm != IDLE);

endmodule
